// File: rtl/pc_seq_pkg.sv
// ----------------------------------------------------------------------------
// pc_seq_pkg
//
// Shared definitions for the PC fetch sequencer:
//   - PC_W / CNT_W : width of the program counter and the retired count
//   - PC_INC       : byte stride of one sequential instruction
//   - seq_state_e  : sequencer state encoding (IDLE, FETCH, ISSUE, HALTED)
//   - isMisaligned : helper used by the optional alignment check
// ----------------------------------------------------------------------------
package pc_seq_pkg;

    localparam int PC_W   = 64;
    localparam int CNT_W  = 32;
    localparam int PC_INC = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } seq_state_e;

    // Instructions are word sized, so any address with low bits set cannot
    // be the start of an instruction.
    function automatic logic isMisaligned(input logic [PC_W-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// ----------------------------------------------------------------------------
// next_pc_calc
//
// Purely combinational next-PC selection for the fetch sequencer.
//
// Ports:
//   pc_i      in  PC_W  current architectural PC
//   imm_i     in  PC_W  sign-extended word offset (two's complement)
//   branch_i  in  1     conditional branch
//   uncond_i  in  1     unconditional branch (wins over branch_i)
//   zero_i    in  1     ALU zero flag qualifying a conditional branch
//   next_pc_o out PC_W  selected next PC, modulo 2^PC_W
// ----------------------------------------------------------------------------
module next_pc_calc
    import pc_seq_pkg::*;
(
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] imm_i,
    input  logic            branch_i,
    input  logic            uncond_i,
    input  logic            zero_i,
    output logic [PC_W-1:0] next_pc_o
);

    logic [PC_W-1:0] byteOffset;
    logic [PC_W-1:0] targetPc;
    logic [PC_W-1:0] seqPc;
    logic            takeBranch;

    // The offset counts words; shifting left by two turns it into bytes.
    // Negative offsets stay correct because the two's-complement add wraps
    // at PC_W bits exactly like the PC itself.
    always_comb begin
        byteOffset = imm_i << 2;
        targetPc   = pc_i + byteOffset;
        seqPc      = pc_i + PC_W'(PC_INC);
        takeBranch = uncond_i | (branch_i & zero_i);
        next_pc_o  = takeBranch ? targetPc : seqPc;
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Instruction fetch/issue sequencer: owns the architectural PC, requests each
// instruction from instruction memory, presents it to execute, then resolves
// the next PC from the datapath's branch/halt inputs.
//
// Ports:
//   CLK           in   1   clock, rising edge
//   resetl        in   1   asynchronous active-low reset
//   StartPC       in   64  boot/restart address
//   Go            in   1   start/restart pulse (honoured in IDLE/HALTED only)
//   IMemReq       out  1   fetch request (high throughout FETCH)
//   IMemAddr      out  64  fetch address
//   IMemAck       in   1   fetch complete (honoured in FETCH only)
//   InstrValid    out  1   fetched instruction sits in execute this cycle
//   Stall         in   1   datapath hold while in ISSUE
//   Branch        in   1   conditional branch
//   Uncondbranch  in   1   unconditional branch
//   ALUZero       in   1   branch condition
//   Halt          in   1   halt instruction
//   SignExtImm64  in   64  branch word offset
//   AlignFault    out  1   misaligned PC detected (PC_ALIGN_CHECK_EN only)
//   CurrentPC     out  64  architectural PC
//   Halted        out  1   halt status
//   InstrCount    out  32  retired-instruction count (wraps)
//
// Build option:
//   PC_ALIGN_CHECK_EN  adds AlignFault and refuses to load a misaligned
//                      StartPC or NextPC, halting instead.
// ----------------------------------------------------------------------------
module pc_fetch_sequencer
    import pc_seq_pkg::*;
(
    input  logic              CLK,
    input  logic              resetl,
    input  logic [PC_W-1:0]   StartPC,
    input  logic              Go,
    output logic              IMemReq,
    output logic [PC_W-1:0]   IMemAddr,
    input  logic              IMemAck,
    output logic              InstrValid,
    input  logic              Stall,
    input  logic              Branch,
    input  logic              Uncondbranch,
    input  logic              ALUZero,
    input  logic              Halt,
    input  logic [PC_W-1:0]   SignExtImm64,
`ifdef PC_ALIGN_CHECK_EN
    output logic              AlignFault,
`endif
    output logic [PC_W-1:0]   CurrentPC,
    output logic              Halted,
    output logic [CNT_W-1:0]  InstrCount
);

    seq_state_e       state_q,  state_d;
    logic [PC_W-1:0]  pc_q,     pc_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [PC_W-1:0]  nextPc;

`ifdef PC_ALIGN_CHECK_EN
    logic             fault_q,  fault_d;
`endif

    next_pc_calc u_next_pc_calc (
        .pc_i      (pc_q),
        .imm_i     (SignExtImm64),
        .branch_i  (Branch),
        .uncond_i  (Uncondbranch),
        .zero_i    (ALUZero),
        .next_pc_o (nextPc)
    );

    // State and architectural registers. Reset is asynchronous so that the
    // memory request drops immediately, even in the middle of a fetch.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`endif

    // Next-state logic. The PC only moves on a Go from IDLE/HALTED or on an
    // unstalled ISSUE, so IMemAddr (driven straight from the PC) is
    // automatically stable for the whole of FETCH.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
`ifdef PC_ALIGN_CHECK_EN
        fault_d  = fault_q;
`endif

        case (state_q)
            IDLE, HALTED: begin
                if (Go) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (isMisaligned(StartPC)) begin
                        fault_d  = 1'b1;
                        halted_d = 1'b1;
                        state_d  = HALTED;
                    end else begin
                        pc_d     = StartPC;
                        halted_d = 1'b0;
                        fault_d  = 1'b0;
                        state_d  = FETCH;
                    end
`else
                    pc_d     = StartPC;
                    halted_d = 1'b0;
                    state_d  = FETCH;
`endif
                end
            end

            FETCH: begin
                if (IMemAck) begin
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                // A stalled issue keeps the instruction in execute; the
                // resolve inputs are only meaningful once the stall lifts.
                if (!Stall) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (Halt) begin
                        halted_d = 1'b1;
                        state_d  = HALTED;
                    end
`ifdef PC_ALIGN_CHECK_EN
                    else if (isMisaligned(nextPc)) begin
                        fault_d  = 1'b1;
                        halted_d = 1'b1;
                        state_d  = HALTED;
                    end
`endif
                    else begin
                        pc_d    = nextPc;
                        state_d = FETCH;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        IMemReq    = (state_q == FETCH);
        InstrValid = (state_q == ISSUE);
        IMemAddr   = pc_q;
        CurrentPC  = pc_q;
        Halted     = halted_q;
        InstrCount = cnt_q;
`ifdef PC_ALIGN_CHECK_EN
        AlignFault = fault_q;
`endif
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_sequencer
//
// Self-checking bench for pc_fetch_sequencer: table of branch-resolution
// vectors, hand-written multi-cycle sequences, and a randomized run checked
// against a behavioural model of the sequencer.
// ----------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

    logic        CLK;
    logic        resetl;
    logic [63:0] StartPC;
    logic        Go;
    logic        IMemReq;
    logic [63:0] IMemAddr;
    logic        IMemAck;
    logic        InstrValid;
    logic        Stall;
    logic        Branch;
    logic        Uncondbranch;
    logic        ALUZero;
    logic        Halt;
    logic [63:0] SignExtImm64;
    logic [63:0] CurrentPC;
    logic        Halted;
    logic [31:0] InstrCount;
`ifdef PC_ALIGN_CHECK_EN
    logic        AlignFault;
`endif

    int total = 0;
    int bad   = 0;

    // Behavioural model: phase 0=idle 1=fetch 2=issue 3=halted
    int          mPhase;
    logic [63:0] mPc;
    logic [31:0] mCnt;
    logic        mHalted;

    pc_fetch_sequencer dut (
        .CLK          (CLK),
        .resetl       (resetl),
        .StartPC      (StartPC),
        .Go           (Go),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemAck      (IMemAck),
        .InstrValid   (InstrValid),
        .Stall        (Stall),
        .Branch       (Branch),
        .Uncondbranch (Uncondbranch),
        .ALUZero      (ALUZero),
        .Halt         (Halt),
        .SignExtImm64 (SignExtImm64),
`ifdef PC_ALIGN_CHECK_EN
        .AlignFault   (AlignFault),
`endif
        .CurrentPC    (CurrentPC),
        .Halted       (Halted),
        .InstrCount   (InstrCount)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        string       name;
        logic [63:0] pc;
        logic        br;
        logic        ub;
        logic        z;
        logic [63:0] imm;
        logic [63:0] expNext;
    } vec_t;

    vec_t vecs[6];

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".IMemReq"},    64'(IMemReq),    64'(mPhase == 1));
        checkVal({tag, ".InstrValid"}, 64'(InstrValid), 64'(mPhase == 2));
        checkVal({tag, ".IMemAddr"},   IMemAddr,        mPc);
        checkVal({tag, ".CurrentPC"},  CurrentPC,       mPc);
        checkVal({tag, ".Halted"},     64'(Halted),     64'(mHalted));
        checkVal({tag, ".InstrCount"}, 64'(InstrCount), 64'(mCnt));
    endtask

    task automatic modelReset();
        mPhase  = 0;
        mPc     = '0;
        mCnt    = '0;
        mHalted = 1'b0;
    endtask

    // Drive one cycle of inputs, let the clock edge take them, and advance
    // the model with the same inputs.
    task automatic applyStimulus(input logic go, input logic [63:0] start, input logic ack,
                                 input logic stall, input logic br, input logic ub,
                                 input logic z, input logic halt, input logic [63:0] imm);
        Go = go; StartPC = start; IMemAck = ack; Stall = stall;
        Branch = br; Uncondbranch = ub; ALUZero = z; Halt = halt; SignExtImm64 = imm;
        @(posedge CLK);
        #1;
        case (mPhase)
            0, 3: if (go) begin mPc = start; mHalted = 1'b0; mPhase = 1; end
            1:    if (ack) mPhase = 2;
            2:    if (!stall) begin
                      mCnt = mCnt + 32'd1;
                      if (halt) begin
                          mHalted = 1'b1;
                          mPhase  = 3;
                      end else begin
                          if (ub || (br && z)) mPc = mPc + imm * 64'd4;
                          else                 mPc = mPc + 64'd4;
                          mPhase = 1;
                      end
                  end
            default: ;
        endcase
    endtask

    task automatic idleCycle(input logic ack);
        applyStimulus(1'b0, 64'h0, ack, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    task automatic doReset();
        resetl = 1'b0;
        Go = 0; StartPC = 0; IMemAck = 0; Stall = 0;
        Branch = 0; Uncondbranch = 0; ALUZero = 0; Halt = 0; SignExtImm64 = 0;
        modelReset();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        resetl = 1'b1;
    endtask

    initial begin
        vecs[0] = '{"beqTaken",   64'h2000, 1'b1, 1'b0, 1'b1, -64'd2, 64'h1FF8};
        vecs[1] = '{"beqNotTkn",  64'h2000, 1'b1, 1'b0, 1'b0, -64'd2, 64'h2004};
        vecs[2] = '{"uncondPrio", 64'h100,  1'b1, 1'b1, 1'b0, 64'd5,  64'h114};
        vecs[3] = '{"seqWrap",    64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b0, 64'd0, 64'h0};
        vecs[4] = '{"zeroNoBr",   64'h40,   1'b0, 1'b0, 1'b1, 64'd100, 64'h44};
        vecs[5] = '{"brWrap",     64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 1'b1, 1'b0, 64'd8, 64'h10};

        // Reset state, with IMemAck ignored while idle
        doReset();
        checkOutput("reset");
        idleCycle(1'b1);
        checkOutput("idleAckIgnored");

        // Table-driven next-PC vectors
        for (int i = 0; i < 6; i++) begin
            doReset();
            applyStimulus(1'b1, vecs[i].pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
            checkVal({vecs[i].name, ".fetchAddr"}, IMemAddr, vecs[i].pc);
            idleCycle(1'b1);
            checkOutput({vecs[i].name, ".issue"});
            applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, vecs[i].br, vecs[i].ub, vecs[i].z, 1'b0, vecs[i].imm);
            checkVal({vecs[i].name, ".nextAddr"}, IMemAddr, vecs[i].expNext);
            checkOutput({vecs[i].name, ".after"});
        end

        // Three sequential instructions from 0x1000 at full throughput
        doReset();
        applyStimulus(1'b1, 64'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            checkVal("seqFetchAddr", IMemAddr, 64'h1000 + 64'(4 * i));
            checkVal("seqFetchReq", 64'(IMemReq), 64'd1);
            idleCycle(1'b1);
            checkVal("seqIssueValid", 64'(InstrValid), 64'd1);
            idleCycle(1'b0);
        end
        checkVal("seqCount", 64'(InstrCount), 64'd3);
        checkOutput("seqEnd");

        // Delayed ack keeps address stable; stall holds PC and count
        doReset();
        applyStimulus(1'b1, 64'h3000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 4; i++) begin
            idleCycle(1'b0);
            checkVal("ackWaitAddr", IMemAddr, 64'h3000);
            checkVal("ackWaitReq", 64'(IMemReq), 64'd1);
        end
        idleCycle(1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'h10);
            checkVal("stallValid", 64'(InstrValid), 64'd1);
            checkVal("stallPc", CurrentPC, 64'h3000);
            checkVal("stallCnt", 64'(InstrCount), 64'd0);
        end
        idleCycle(1'b0);
        checkVal("postStallPc", CurrentPC, 64'h3004);
        checkVal("postStallCnt", 64'(InstrCount), 64'd1);

        // Halt, stay halted, restart on Go, Go ignored during FETCH
        doReset();
        applyStimulus(1'b1, 64'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        idleCycle(1'b1);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h40);
        checkVal("haltFlag", 64'(Halted), 64'd1);
        checkVal("haltPc", CurrentPC, 64'h8000);
        checkVal("haltCnt", 64'(InstrCount), 64'd1);
        checkVal("haltReq", 64'(IMemReq), 64'd0);
        idleCycle(1'b1);
        checkOutput("haltHold");
        applyStimulus(1'b1, 64'h9000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        checkVal("restartPc", CurrentPC, 64'h9000);
        checkVal("restartHalted", 64'(Halted), 64'd0);
        checkVal("restartReq", 64'(IMemReq), 64'd1);
        applyStimulus(1'b1, 64'hAAA0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        checkVal("goIgnoredPc", CurrentPC, 64'h9000);
        checkOutput("goIgnored");

        // Asynchronous reset in the middle of a fetch
        idleCycle(1'b1);
        idleCycle(1'b0);
        checkVal("preResetReq", 64'(IMemReq), 64'd1);
        #3;
        resetl = 1'b0;
        #1;
        modelReset();
        checkOutput("asyncReset");
        @(posedge CLK);
        #1;
        resetl = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idleCycle(1'b1);
            checkOutput("postResetIdle");
        end

        // Randomized run against the model
        doReset();
        for (int i = 0; i < 400; i++) begin
            logic [63:0] rStart;
            logic [63:0] rImm;
            rStart = {$urandom, $urandom & 32'hFFFF_FFFC};
            rImm   = ($urandom_range(0, 1) == 1) ? {32'hFFFF_FFFF, $urandom} : 64'($urandom_range(0, 4096));
            applyStimulus($urandom_range(0, 3) == 0, rStart, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 9) == 0, rImm);
            checkOutput("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
